slot_game_fsm: RTL

//   Main game controller of the slot-machine term project: manages bets, credits,

---
 rtl/slot_game_fsm.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/slot_game_fsm.sv
// Slot-machine game controller: bets, credits, reel spin/stop, payout evaluation.
// Latency: all outputs registered; a transition shows on state one cycle after its cause.
// Backpressure: none; button pulses are consumed only in states that accept them, otherwise dropped.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   btn_start, btn_stop, btn_bet  one-cycle debounced button pulses
//   state                         4-bit state code shared with buzzer / 7-seg / LED stages
//   reel0..reel2                  reel symbols 0..7 (7 = jackpot)
//   credit, bet, win_amount       current credits, current bet (1..3), last payout
//   game_over                     high while in GAME_OVER
module slot_game_fsm #(
  parameter int unsigned CREDIT_W       = 8,
  parameter int unsigned INIT_CREDIT    = 10,
  parameter int unsigned START_SPIN_CYC = 5_000_000,
  parameter int unsigned SPIN_MAX_CYC   = 150_000_000,
  parameter int unsigned DISPLAY_CYC    = 100_000_000,
  parameter int unsigned REEL_STEP_CYC  = 2_500_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_start,
  input  logic                btn_stop,
  input  logic                btn_bet,
  output logic [3:0]          state,
  output logic [2:0]          reel0,
  output logic [2:0]          reel1,
  output logic [2:0]          reel2,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          bet,
  output logic [CREDIT_W-1:0] win_amount,
  output logic                game_over
);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_BET_SELECT   = 4'd1,
    S_BET_DEDUCT   = 4'd2,
    S_START_SPIN   = 4'd4,
    S_SPIN_WAIT    = 4'd5,
    S_EVALUATE     = 4'd6,
    S_WIN_DISPLAY  = 4'd7,
    S_LOSE_DISPLAY = 4'd8,
    S_GAME_OVER    = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         timer_q, timer_d;
  logic [31:0]         reel_cnt_q, reel_cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [2:0]          reel0_q, reel0_d;
  logic [2:0]          reel1_q, reel1_d;
  logic [2:0]          reel2_q, reel2_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          bet_q, bet_d;
  logic [CREDIT_W-1:0] win_q, win_d;
  logic                game_over_q, game_over_d;

  logic [CREDIT_W-1:0] bet_ext;
  logic [3:0]          mult;
  logic [5:0]          prod;
  logic [CREDIT_W-1:0] payout;
  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W-1:0] credit_sat;

  assign bet_ext = CREDIT_W'(bet_q);

  // Galois LFSR, taps 16'hB400; free-running in every state.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Payout of the currently held reels (valid in EVALUATE, reels latched the cycle before).
  always_comb begin
    mult = 4'd0;
    if (reel0_q == reel1_q && reel1_q == reel2_q)
      mult = (reel0_q == 3'd7) ? 4'd10 : 4'd5;
    else if (reel0_q == reel1_q || reel1_q == reel2_q || reel0_q == reel2_q)
      mult = 4'd2;
    prod       = {4'b0000, bet_q} * {2'b00, mult};
    payout     = CREDIT_W'(prod);
    credit_sum = {1'b0, credit_q} + {1'b0, payout};
    credit_sat = credit_sum[CREDIT_W] ? {CREDIT_W{1'b1}} : credit_sum[CREDIT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    bet_d      = bet_q;
    win_d      = win_q;
    reel0_d    = reel0_q;
    reel1_d    = reel1_q;
    reel2_d    = reel2_q;
    reel_cnt_d = '0;

    // Reel animation: the step counter runs across START_SPIN and SPIN_WAIT
    // without restarting, and is held at zero everywhere else so it starts
    // fresh on entry to START_SPIN.
    if (state_q == S_START_SPIN || state_q == S_SPIN_WAIT) begin
      if (reel_cnt_q == REEL_STEP_CYC - 1) begin
        reel0_d = reel0_q + 3'd1;
        reel1_d = reel1_q + 3'd1;
        reel2_d = reel2_q + 3'd1;
      end else begin
        reel_cnt_d = reel_cnt_q + 32'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (credit_q == '0)
          state_d = S_GAME_OVER;
        else if (btn_start || btn_bet)
          state_d = S_BET_SELECT;
      end
      S_BET_SELECT: begin
        // Start has priority over bet; an unaffordable start is simply dropped.
        if (btn_start) begin
          if (credit_q >= bet_ext)
            state_d = S_BET_DEDUCT;
        end else if (btn_bet) begin
          bet_d = (bet_q == 2'd3) ? 2'd1 : bet_q + 2'd1;
        end
      end
      S_BET_DEDUCT: begin
        credit_d = credit_q - bet_ext;
        win_d    = '0;
        state_d  = S_START_SPIN;
      end
      S_START_SPIN: begin
        if (timer_q == START_SPIN_CYC - 1)
          state_d = S_SPIN_WAIT;
      end
      S_SPIN_WAIT: begin
        // Final symbols come from the LFSR value of the stop cycle itself.
        if (btn_stop || timer_q == SPIN_MAX_CYC - 1) begin
          reel0_d = lfsr_q[2:0];
          reel1_d = lfsr_q[5:3];
          reel2_d = lfsr_q[8:6];
          state_d = S_EVALUATE;
        end
      end
      S_EVALUATE: begin
        win_d    = payout;
        credit_d = credit_sat;
        state_d  = (payout != '0) ? S_WIN_DISPLAY : S_LOSE_DISPLAY;
      end
      S_WIN_DISPLAY, S_LOSE_DISPLAY: begin
        if (timer_q == DISPLAY_CYC - 1)
          state_d = S_IDLE;
      end
      S_GAME_OVER: begin
        if (btn_start) begin
          credit_d = CREDIT_W'(INIT_CREDIT);
          bet_d    = 2'd1;
          win_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One shared timer: restarts on every state change.
    timer_d     = (state_d != state_q) ? 32'd0 : timer_q + 32'd1;
    game_over_d = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      reel_cnt_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      reel0_q     <= '0;
      reel1_q     <= '0;
      reel2_q     <= '0;
      credit_q    <= CREDIT_W'(INIT_CREDIT);
      bet_q       <= 2'd1;
      win_q       <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      reel_cnt_q  <= reel_cnt_d;
      lfsr_q      <= lfsr_d;
      reel0_q     <= reel0_d;
      reel1_q     <= reel1_d;
      reel2_q     <= reel2_d;
      credit_q    <= credit_d;
      bet_q       <= bet_d;
      win_q       <= win_d;
      game_over_q <= game_over_d;
    end
  end

  assign state      = state_q;
  assign reel0      = reel0_q;
  assign reel1      = reel1_q;
  assign reel2      = reel2_q;
  assign credit     = credit_q;
  assign bet        = bet_q;
  assign win_amount = win_q;
  assign game_over  = game_over_q;

endmodule
